// File: rtl/disp_scan_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// disp_scan_ctrl_pkg
// Shared definitions for the multiplexed four-digit display scanner.
//   scan_state_t : FSM state encoding (IDLE / BLANK / SHOW)
//   AN_OFF       : all digit enables inactive (active-low anodes)
//   DIGITS       : number of scanned digits
//   nibble_sel() : picks hex digit i out of a 16-bit value
// -----------------------------------------------------------------------------
package disp_scan_ctrl_pkg;

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      BLANK = 2'd1,
      SHOW  = 2'd2
   } scan_state_t;

   localparam logic [3:0] AN_OFF = 4'b1111;
   localparam int         DIGITS = 4;

   function automatic logic [3:0] nibble_sel(input logic [15:0] v, input logic [1:0] i);
      return v[4*i +: 4];
   endfunction

endpackage

// File: rtl/disp_scan_ctrl_tick.sv
// -----------------------------------------------------------------------------
// scan_tick_gen
// Slot counter for the display scanner. Counts 0..CLK_DIV-1 while run is high
// and holds at 0 otherwise.
//   clk, rst  : clock, asynchronous active-high reset
//   run       : counting enabled (scanner active and enabled)
//   tick      : counter is on the last cycle of the slot
//   show_nxt  : the count entering on the next edge lies in the SHOW phase
// -----------------------------------------------------------------------------
module scan_tick_gen #(
   parameter int CLK_DIV   = 50000,
   parameter int BLANK_CYC = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic run,
   output logic tick,
   output logic show_nxt
);

   localparam int CW = $clog2(CLK_DIV);

   logic [CW-1:0] count;
   logic [CW-1:0] count_nxt;

   always_comb begin
      tick = (count == CW'(CLK_DIV - 1));
      if (!run || tick) begin
         count_nxt = '0;
      end else begin
         count_nxt = count + CW'(1);
      end
      // The FSM state register updates on the same edge as the counter, so
      // the phase decision is made on the incoming count value.
      show_nxt = (count_nxt >= CW'(BLANK_CYC));
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count <= '0;
      end else begin
         count <= count_nxt;
      end
   end

endmodule

// File: rtl/disp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// disp_scan_ctrl
// Time-multiplexed scan controller for a four-digit seven-segment display with
// anti-ghost blanking, leading-zero suppression and frame-synchronous updates.
//   clk, rst : clock, asynchronous active-high reset
//   en       : scanning enabled
//   data     : four hex digits, [15:12] is digit 3
//   load     : one-cycle strobe capturing data
//   dot      : live decimal-point request per digit (active-high)
//   an       : registered digit enables (active-low)
//   num      : registered nibble for the segment decoder
//   dp       : registered decimal point (active-low)
//   pend     : a loaded value is waiting for the next frame boundary
//   frame    : one-cycle pulse at the start of digit 0
// -----------------------------------------------------------------------------
module disp_scan_ctrl
   import disp_scan_ctrl_pkg::*;
#(
   parameter int CLK_DIV     = 50000,
   parameter int BLANK_CYC   = 16,
   parameter int LZ_SUPPRESS = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        en,
   input  logic [15:0] data,
   input  logic        load,
   input  logic [3:0]  dot,
   output logic [3:0]  an,
   output logic [3:0]  num,
   output logic        dp,
   output logic        pend,
   output logic        frame
);

   scan_state_t state, state_nxt;
   logic [1:0]  idx, idx_nxt;
   logic        frame_nxt;
   logic        tick, show_nxt, run;
   logic [15:0] active, shadow;
   logic [3:0]  lz_mask;
   logic        z3, z2, z1;
   logic [3:0]  an_p0, num_p0;
   logic        dp_p0;

   assign run = en && (state != IDLE);

   scan_tick_gen #(
      .CLK_DIV   (CLK_DIV),
      .BLANK_CYC (BLANK_CYC)
   ) u_tick (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .tick     (tick),
      .show_nxt (show_nxt)
   );

   // A digit is dark when it and every more-significant digit are zero.
   // Digit 0 is always shown.
   assign z3 = (active[15:12] == 4'd0);
   assign z2 = (active[11:8]  == 4'd0);
   assign z1 = (active[7:4]   == 4'd0);
   assign lz_mask = (LZ_SUPPRESS != 0) ? {z3, z3 & z2, z3 & z2 & z1, 1'b0} : 4'b0000;

   always_comb begin
      state_nxt = state;
      idx_nxt   = idx;
      frame_nxt = 1'b0;
      case (state)
         IDLE: begin
            idx_nxt = '0;
            if (en) begin
               state_nxt = BLANK;
               frame_nxt = 1'b1;
            end
         end
         BLANK, SHOW: begin
            if (!en) begin
               state_nxt = IDLE;
               idx_nxt   = '0;
            end else begin
               state_nxt = show_nxt ? SHOW : BLANK;
               if (tick) begin
                  idx_nxt   = idx + 2'd1;
                  frame_nxt = (idx == 2'(DIGITS - 1));
               end
            end
         end
         default: begin
            state_nxt = IDLE;
            idx_nxt   = '0;
         end
      endcase

      // Dropping en blanks the anodes on the very next edge, not one later.
      num_p0 = nibble_sel(active, idx);
      an_p0  = AN_OFF;
      dp_p0  = 1'b1;
      if (en && (state == SHOW) && !lz_mask[idx]) begin
         an_p0 = ~(4'b0001 << idx);
         dp_p0 = ~dot[idx];
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
         idx   <= '0;
         frame <= 1'b0;
      end else begin
         state <= state_nxt;
         idx   <= idx_nxt;
         frame <= frame_nxt;
      end
   end

   // Output stage: one cycle behind state/counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         an  <= AN_OFF;
         num <= 4'd0;
         dp  <= 1'b1;
      end else begin
         an  <= an_p0;
         num <= num_p0;
         dp  <= dp_p0;
      end
   end

   // Display data. The frame boundary is the edge that raises frame, so a
   // value committed there is already in place for digit 0 of that frame.
   // A direct write (idle or coincident with the boundary) supersedes any
   // pending shadow value.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         active <= '0;
         shadow <= '0;
         pend   <= 1'b0;
      end else if (load && ((state == IDLE) || frame_nxt)) begin
         active <= data;
         pend   <= 1'b0;
      end else if (frame_nxt && pend) begin
         active <= shadow;
         pend   <= 1'b0;
      end else if (load) begin
         shadow <= data;
         pend   <= 1'b1;
      end
   end

endmodule

// File: tb/tb_disp_scan_ctrl.sv
// -----------------------------------------------------------------------------
// tb_disp_scan_ctrl
// Directed bench for disp_scan_ctrl with CLK_DIV=8, BLANK_CYC=2, LZ_SUPPRESS=1.
// -----------------------------------------------------------------------------
module tb_disp_scan_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        en;
   logic [15:0] data;
   logic        load;
   logic [3:0]  dot;
   logic [3:0]  an;
   logic [3:0]  num;
   logic        dp;
   logic        pend;
   logic        frame;

   int total = 0;
   int bad   = 0;
   int n;

   disp_scan_ctrl #(
      .CLK_DIV     (8),
      .BLANK_CYC   (2),
      .LZ_SUPPRESS (1)
   ) dut (
      .clk   (clk),
      .rst   (rst),
      .en    (en),
      .data  (data),
      .load  (load),
      .dot   (dot),
      .an    (an),
      .num   (num),
      .dp    (dp),
      .pend  (pend),
      .frame (frame)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Called right after the edge that raised frame. Walks one whole frame:
   // per digit, 2 dark cycles then 6 lit cycles (unless suppressed), num
   // carrying that digit's nibble throughout, frame pulsing again at the end.
   task automatic check_frame(input logic [15:0] val, input logic [3:0] dt,
                              input logic [3:0] supp);
      logic [3:0] one;
      logic [3:0] e_an;
      logic [3:0] e_num;
      logic       e_dp;
      one = 4'b0001;
      for (int d = 0; d < 4; d++) begin
         for (int c = 0; c < 8; c++) begin
            tick();
            e_num = 4'((val >> (4 * d)) & 16'h000f);
            e_an  = 4'hf;
            e_dp  = 1'b1;
            if (c >= 2 && !supp[d]) begin
               e_an = ~(one << d);
               e_dp = ~dt[d];
            end
            chk("scan_an",    {12'd0, an},    {12'd0, e_an});
            chk("scan_num",   {12'd0, num},   {12'd0, e_num});
            chk("scan_dp",    {15'd0, dp},    {15'd0, e_dp});
            chk("scan_pend",  {15'd0, pend},  16'd0);
            chk("scan_frame", {15'd0, frame}, {15'd0, (d == 3 && c == 7)});
         end
      end
   endtask

   // Runs until frame rises (bounded); pend must hold 1 until then.
   task automatic wait_frame(output int cnt);
      cnt = 0;
      do begin
         tick();
         cnt++;
         if (frame !== 1'b1) chk("pend_hold", {15'd0, pend}, 16'd1);
      end while (frame !== 1'b1 && cnt < 64);
   endtask

   initial begin
      rst  = 1'b0;
      en   = 1'b0;
      data = 16'h0000;
      load = 1'b0;
      dot  = 4'b0000;

      // Asynchronous reset, checked before any clock edge
      #2 rst = 1'b1;
      #1;
      chk("rst_an",    {12'd0, an},    16'h000f);
      chk("rst_num",   {12'd0, num},   16'h0000);
      chk("rst_dp",    {15'd0, dp},    16'd1);
      chk("rst_pend",  {15'd0, pend},  16'd0);
      chk("rst_frame", {15'd0, frame}, 16'd0);
      tick();
      tick();
      chk("rst_hold_an", {12'd0, an}, 16'h000f);
      rst = 1'b0;

      // Load in IDLE goes straight to active
      data = 16'h1234;
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("idle_load_pend", {15'd0, pend}, 16'd0);
      chk("idle_an",        {12'd0, an},   16'h000f);

      // Enable: frame one cycle after en sampled
      en = 1'b1;
      tick();
      chk("en_frame", {15'd0, frame}, 16'd1);
      chk("en_pend",  {15'd0, pend},  16'd0);
      check_frame(16'h1234, 4'b0000, 4'b0000);

      // Decimal point only on digit 2 while shown
      dot = 4'b0100;
      check_frame(16'h1234, 4'b0100, 4'b0000);
      dot = 4'b0000;

      // Mid-frame load: held pending until the next boundary
      for (int i = 0; i < 10; i++) tick();
      data = 16'habcd;
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("mid_load_pend", {15'd0, pend}, 16'd1);
      wait_frame(n);
      chk("mid_wait_cycles", 16'(n),         16'd21);
      chk("mid_frame_pend",  {15'd0, pend},  16'd0);
      check_frame(16'habcd, 4'b0000, 4'b0000);

      // Load coincident with the boundary: direct, never pending
      for (int i = 0; i < 31; i++) tick();
      data = 16'h5678;
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("coin_frame", {15'd0, frame}, 16'd1);
      chk("coin_pend",  {15'd0, pend},  16'd0);
      check_frame(16'h5678, 4'b0000, 4'b0000);

      // Leading zeros: only digit 0 lights
      for (int i = 0; i < 5; i++) tick();
      data = 16'h0007;
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("lz_load_pend", {15'd0, pend}, 16'd1);
      wait_frame(n);
      chk("lz_wait_cycles", 16'(n), 16'd26);
      check_frame(16'h0007, 4'b0000, 4'b1110);

      // en dropped mid-SHOW with a pending value: blank next edge, pend kept,
      // value applied at the frame following re-enable
      for (int i = 0; i < 3; i++) tick();
      data = 16'h00c5;
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("endrop_load_pend", {15'd0, pend}, 16'd1);
      tick();
      en = 1'b0;
      tick();
      chk("endrop_an",   {12'd0, an},   16'h000f);
      chk("endrop_dp",   {15'd0, dp},   16'd1);
      chk("endrop_pend", {15'd0, pend}, 16'd1);
      for (int i = 0; i < 3; i++) begin
         tick();
         chk("idle_hold_an",    {12'd0, an},    16'h000f);
         chk("idle_hold_pend",  {15'd0, pend},  16'd1);
         chk("idle_hold_frame", {15'd0, frame}, 16'd0);
      end
      en = 1'b1;
      tick();
      chk("reen_frame", {15'd0, frame}, 16'd1);
      chk("reen_pend",  {15'd0, pend},  16'd0);
      tick();
      chk("reen_num", {12'd0, num}, 16'h0005);
      tick();
      tick();
      chk("reen_an",     {12'd0, an},  16'h000e);
      chk("reen_num_sh", {12'd0, num}, 16'h0005);

      // Reset mid-slot with a pending value
      data = 16'hffff;
      load = 1'b1;
      tick();
      load = 1'b0;
      chk("prerst_pend", {15'd0, pend}, 16'd1);
      chk("prerst_an",   {12'd0, an},   16'h000e);
      #3 rst = 1'b1;
      #1;
      chk("midrst_an",    {12'd0, an},    16'h000f);
      chk("midrst_num",   {12'd0, num},   16'h0000);
      chk("midrst_dp",    {15'd0, dp},    16'd1);
      chk("midrst_pend",  {15'd0, pend},  16'd0);
      chk("midrst_frame", {15'd0, frame}, 16'd0);
      tick();
      chk("midrst_hold_an", {12'd0, an}, 16'h000f);
      rst = 1'b0;

      // en still high: frame one cycle later, active cleared to 0
      tick();
      chk("post_frame", {15'd0, frame}, 16'd1);
      chk("post_pend",  {15'd0, pend},  16'd0);
      tick();
      chk("post_num", {12'd0, num}, 16'h0000);
      tick();
      tick();
      chk("post_an",     {12'd0, an},  16'h000e);
      chk("post_num_sh", {12'd0, num}, 16'h0000);
      en = 1'b0;
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
